// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - radix-2 sequential MUL/IMUL/DIV/IDIV unit, word and byte modes
// Operands are reduced to magnitudes on accept; signs are reapplied in FIX.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         func,
    input  logic               word_op,
    input  logic [2*WIDTH-1:0] x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               cfo,
    output logic               ofo,
    output logic               div_exc
);
    localparam int W  = WIDTH;
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     func_q, func_d;
    logic           word_q, word_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           xneg_q, xneg_d;
    logic           sneg_q, sneg_d;
    logic           ovf_q, ovf_d;
    logic [2*W-1:0] out_q, out_d;
    logic           cfo_q, cfo_d;
    logic           exc_q, exc_d;

    logic [2*W-1:0] xv, xmag, div_next, mul_next, prod, mul_out, div_out;
    logic [W-1:0]   yv, ymag, hi, ntop, qm, rm, q, r;
    logic [W:0]     top, sub;
    logic           xneg, yneg, ge, mul_cf, qovf;

    always_comb begin
        xv = '0;
        case ({func[1], word_op})
            2'b11:   xv = x;
            2'b00:   xv = {{(W+H){func[0] & x[H-1]}}, x[H-1:0]};
            default: xv = {{W{func[0] & x[W-1]}}, x[W-1:0]};
        endcase
        xneg = func[0] & xv[2*W-1];
        xmag = xneg ? -xv : xv;
        yv   = word_op ? y : {{H{func[0] & y[H-1]}}, y[H-1:0]};
        yneg = func[0] & yv[W-1];
        ymag = yneg ? -yv : yv;
        // Quotient needs more than N bits exactly when the dividend's upper half >= divisor
        hi   = word_op ? xmag[2*W-1:W] : {{H{1'b0}}, xmag[W-1:H]};

        // Shifted-in window of the partial remainder, N+1 bits wide
        top  = word_q ? acc_q[2*W-1:W-1] : {{H{1'b0}}, acc_q[W-1:H-1]};
        sub  = top - {1'b0, opb_q};
        ge   = ~sub[W];
        ntop = ge ? sub[W-1:0] : top[W-1:0];
        div_next = word_q ? {ntop, acc_q[W-2:0], ge}
                          : {{W{1'b0}}, ntop[H-1:0], acc_q[H-2:0], ge};
        mul_next = opb_q[0] ? acc_q + opa_q : acc_q;

        prod    = sneg_q ? -acc_q : acc_q;
        mul_out = word_q ? prod : {{W{1'b0}}, prod[W-1:0]};
        if (func_q[0])
            mul_cf = word_q ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[W-1:H] != {H{prod[H-1]}});
        else
            mul_cf = word_q ? (|prod[2*W-1:W]) : (|prod[W-1:H]);

        qm   = word_q ? acc_q[W-1:0]   : {{H{1'b0}}, acc_q[H-1:0]};
        rm   = word_q ? acc_q[2*W-1:W] : {{H{1'b0}}, acc_q[W-1:H]};
        q    = sneg_q ? -qm : qm;
        r    = xneg_q ? -rm : rm;
        // Signed quotient magnitude must stay below 2^(N-1); -2^(N-1) traps too
        qovf = ovf_q | (func_q[0] & (word_q ? qm[W-1] : qm[H-1]));
        div_out = word_q ? {r, q} : {{W{1'b0}}, r[H-1:0], q[H-1:0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        word_d  = word_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        xneg_d  = xneg_q;
        sneg_d  = sneg_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        cfo_d   = cfo_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    func_d = func;
                    word_d = word_op;
                    xneg_d = xneg;
                    sneg_d = xneg ^ yneg;
                    ovf_d  = (hi >= ymag);
                    acc_d  = func[1] ? xmag : '0;
                    opa_d  = xmag;
                    opb_d  = ymag;
                    cnt_d  = word_op ? CW'(W) : CW'(H);
                    if (func[1] && ymag == '0) begin
                        out_d   = '0;
                        cfo_d   = 1'b0;
                        exc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (func_q[1]) begin
                    acc_d = div_next;
                end else begin
                    acc_d = mul_next;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                if (!func_q[1]) begin
                    out_d = mul_out;
                    cfo_d = mul_cf;
                    exc_d = 1'b0;
                end else begin
                    out_d = qovf ? '0 : div_out;
                    cfo_d = 1'b0;
                    exc_d = qovf;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            word_q  <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            xneg_q  <= 1'b0;
            sneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            cfo_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            xneg_q  <= xneg_d;
            sneg_q  <= sneg_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            cfo_q   <= cfo_d;
            exc_q   <= exc_d;
        end
    end

    assign busy    = (state_q == CALC) || (state_q == FIX);
    assign done    = (state_q == DONE);
    assign out     = out_q;
    assign cfo     = cfo_q;
    assign ofo     = cfo_q;
    assign div_exc = exc_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with an arithmetic reference model
module tb_muldiv_seq;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    func;
    logic          word_op;
    logic [31:0]   x;
    logic [15:0]   y;
    logic          busy, done, cfo, ofo, div_exc;
    logic [31:0]   out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .word_op(word_op),
        .x(x), .y(y), .busy(busy), .done(done), .out(out),
        .cfo(cfo), .ofo(ofo), .div_exc(div_exc)
    );

    typedef struct {
        logic [1:0]  f;
        logic        wd;
        logic [31:0] xi;
        logic [15:0] yi;
        logic [31:0] eo;
        logic        ec;
        logic        ee;
        int          lat;
    } vec_t;

    task automatic model(input logic [1:0] f, input logic wd, input logic [31:0] xi,
                         input logic [15:0] yi, output logic [31:0] eo, output logic ec,
                         output logic ee, output int elat);
        longint n, mn, m2n, a, b, p, d, v, qq, rr, lim;
        n    = wd ? 16 : 8;
        mn   = (longint'(1) << n) - 1;
        m2n  = (longint'(1) << (2 * n)) - 1;
        lim  = (mn + 1) / 2;
        a    = longint'(xi) & mn;
        b    = longint'(yi) & mn;
        d    = longint'(xi) & m2n;
        eo   = '0;
        ec   = 1'b0;
        ee   = 1'b0;
        elat = int'(n) + 2;
        case (f)
            2'd0: begin
                p  = a * b;
                eo = 32'(p);
                ec = (p >> n) != 0;
            end
            2'd1: begin
                if (a >= lim) a = a - (mn + 1);
                if (b >= lim) b = b - (mn + 1);
                p  = a * b;
                eo = 32'(p & m2n);
                ec = (p < -lim) || (p >= lim);
            end
            default: begin
                v = b;
                if (f == 2'd3) begin
                    if (d > (m2n >> 1)) d = d - (m2n + 1);
                    if (v >= lim) v = v - (mn + 1);
                end
                if (v == 0) begin
                    ee   = 1'b1;
                    elat = 1;
                end else begin
                    qq = d / v;
                    rr = d % v;
                    if (f == 2'd2) ee = (qq > mn);
                    else           ee = (qq >= lim) || (qq <= -lim);
                    if (!ee) eo = 32'((((rr & mn) << n) | (qq & mn)));
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] f, input logic wd, input logic [31:0] xi,
                          input logic [15:0] yi, output logic [31:0] oo, output logic oc,
                          output logic oof, output logic oe, output int lat, output logic pulse_bad);
        @(negedge clk);
        func = f; word_op = wd; x = xi; y = yi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        oo = out; oc = cfo; oof = ofo; oe = div_exc;
        @(posedge clk); #1;
        pulse_bad = (done !== 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; func = 2'd0; word_op = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, cfo, ofo, div_exc} !== 5'b0 || out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b done=%b out=%h cfo=%b ofo=%b exc=%b want all 0",
                     busy, done, out, cfo, ofo, div_exc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vecs[12];
        logic [31:0] oo;
        logic oc, oof, oe, pb;
        int lat;
        vecs[0]  = '{2'd0, 1'b1, 32'h00001234, 16'h0100, 32'h00123400, 1'b1, 1'b0, 18};
        vecs[1]  = '{2'd1, 1'b0, 32'h000000FE, 16'h0003, 32'h0000FFFA, 1'b0, 1'b0, 10};
        vecs[2]  = '{2'd2, 1'b1, 32'h00010005, 16'h0002, 32'h00018002, 1'b0, 1'b0, 18};
        vecs[3]  = '{2'd3, 1'b0, 32'h0000FFF9, 16'h0002, 32'h0000FFFD, 1'b0, 1'b0, 10};
        vecs[4]  = '{2'd2, 1'b1, 32'h12345678, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1};
        vecs[5]  = '{2'd2, 1'b1, 32'h00020000, 16'h0001, 32'h00000000, 1'b0, 1'b1, 18};
        vecs[6]  = '{2'd3, 1'b0, 32'h0000FF80, 16'h0001, 32'h00000000, 1'b0, 1'b1, 10};
        vecs[7]  = '{2'd1, 1'b1, 32'h00008000, 16'h8000, 32'h40000000, 1'b1, 1'b0, 18};
        vecs[8]  = '{2'd2, 1'b0, 32'h000001FF, 16'h0002, 32'h000001FF, 1'b0, 1'b0, 10};
        vecs[9]  = '{2'd2, 1'b0, 32'h00000200, 16'h0002, 32'h00000000, 1'b0, 1'b1, 10};
        vecs[10] = '{2'd3, 1'b0, 32'h0000FF81, 16'h0001, 32'h00000081, 1'b0, 1'b0, 10};
        vecs[11] = '{2'd3, 1'b1, 32'hFFFFFFF9, 16'hFFFE, 32'hFFFF0003, 1'b0, 1'b0, 18};
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f, vecs[i].wd, vecs[i].xi, vecs[i].yi, oo, oc, oof, oe, lat, pb);
            n_tests++;
            if (oo !== vecs[i].eo || oc !== vecs[i].ec || oof !== vecs[i].ec || oe !== vecs[i].ee) begin
                n_fail++;
                $display("FAIL directed[%0d] got out=%h cfo=%b ofo=%b exc=%b want out=%h cfo=ofo=%b exc=%b",
                         i, oo, oc, oof, oe, vecs[i].eo, vecs[i].ec, vecs[i].ee);
            end
            n_tests++;
            if (lat !== vecs[i].lat || pb) begin
                n_fail++;
                $display("FAIL directed_latency[%0d] got %0d (pulse_extra=%b) want %0d",
                         i, lat, pb, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] xi, oo, eo;
        logic [15:0] yi;
        logic [1:0]  f;
        logic wd, oc, oof, oe, ec, ee, pb;
        int lat, elat, mode;
        for (int i = 0; i < 80; i++) begin
            f    = 2'($urandom_range(0, 3));
            wd   = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            xi   = $urandom;
            yi   = 16'($urandom);
            if (mode == 1) yi = '0;
            if (mode == 2) xi = xi & (wd ? 32'h0000FFFF : 32'h000000FF);
            if (mode == 3) xi = wd ? {{16{xi[15]}}, xi[15:0]} : {16'h0, {8{xi[7]}}, xi[7:0]};
            model(f, wd, xi, yi, eo, ec, ee, elat);
            run_op(f, wd, xi, yi, oo, oc, oof, oe, lat, pb);
            n_tests++;
            if (oo !== eo || oc !== ec || oof !== ec || oe !== ee) begin
                n_fail++;
                $display("FAIL random[%0d] f=%0d wd=%b x=%h y=%h got out=%h cfo=%b ofo=%b exc=%b want out=%h cfo=ofo=%b exc=%b",
                         i, f, wd, xi, yi, oo, oc, oof, oe, eo, ec, ee);
            end
            n_tests++;
            if (lat !== elat || pb) begin
                n_fail++;
                $display("FAIL random_latency[%0d] got %0d (pulse_extra=%b) want %0d", i, lat, pb, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        func = 2'd0; word_op = 1'b1; x = 32'h000000FF; y = 16'h0101; start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        func = 2'd2; y = 16'h0000; x = $urandom;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy got %b want 1", busy);
        end
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            x = $urandom;
        end
        start = 1'b0;
        n_tests++;
        if (out !== 32'h0000FFFF || cfo !== 1'b0 || div_exc !== 1'b0 || lat !== 18) begin
            n_fail++;
            $display("FAIL b2b_result got out=%h cfo=%b exc=%b lat=%0d want out=0000ffff cfo=0 exc=0 lat=18",
                     out, cfo, div_exc, lat);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b done=%b out=%h want busy=0 done=0 out=0000ffff",
                     busy, done, out);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] oo;
        logic oc, oof, oe, pb;
        int lat;
        @(negedge clk);
        func = 2'd0; word_op = 1'b1; x = 32'h0000ABCD; y = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0 || cfo !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b done=%b out=%h cfo=%b want all 0", busy, done, out, cfo);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(2'd0, 1'b1, 32'h00000003, 16'h0005, oo, oc, oof, oe, lat, pb);
        n_tests++;
        if (oo !== 32'd15 || oc !== 1'b0 || oe !== 1'b0 || lat !== 18) begin
            n_fail++;
            $display("FAIL post_reset_mul got out=%h cfo=%b exc=%b lat=%0d want out=0000000f cfo=0 exc=0 lat=18",
                     oo, oc, oe, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired with %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
